// File: rtl/psum_binarizer.sv
// -----------------------------------------------------------------------------
// psum_binarizer
//
// Sits at the output end of the PE-row chain. It sums PASSES signed partial
// sums per output in a saturating accumulator and compares each finished sum
// against a programmable threshold. Nine binary results are packed MSB-first
// into a 9-bit activation word, which is offered downstream on a valid/ready
// handshake. The word has the same format a PE row takes on activation_in.
//
// Ports
//   clk_in          clock, all logic on the rising edge
//   rst_in          synchronous active-high reset
//   psum_valid_in   psum_in carries a value this cycle
//   psum_in         signed partial sum (WIDTH bits)
//   psum_ready_out  block accepts psum_in this cycle
//   thr_load_in     load thr_in into the threshold register
//   thr_in          signed threshold (ACC_WIDTH bits)
//   act_out         packed binary activations, first result in bit 8
//   act_valid_out   act_out holds a complete word
//   act_ready_in    downstream takes act_out this cycle
// -----------------------------------------------------------------------------
module psum_binarizer #(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 16,
    parameter int PASSES    = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        psum_valid_in,
    input  logic signed [WIDTH-1:0]     psum_in,
    output logic                        psum_ready_out,
    input  logic                        thr_load_in,
    input  logic signed [ACC_WIDTH-1:0] thr_in,
    output logic [8:0]                  act_out,
    output logic                        act_valid_out,
    input  logic                        act_ready_in
);

    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd8;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Clamp a one-bit-wider sum back into the accumulator range. The two top
    // bits differ only when the addition left the representable range.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH:0] v
    );
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
            return v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return v[ACC_WIDTH-1:0];
    endfunction

    // State
    logic [PW-1:0]               pass_cnt_q, pass_cnt_d;
    logic [3:0]                  bit_cnt_q,  bit_cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q,      acc_d;
    logic signed [ACC_WIDTH-1:0] thr_q,      thr_d;
    // Bit 0 of a word is never stored here: it goes straight to the output
    // register together with bits 8..1.
    logic [8:1]                  pack_q,     pack_d;
    logic [8:0]                  out_q,      out_d;
    logic                        vld_q,      vld_d;

    // Datapath
    logic                        accept;
    logic                        last_pass;
    logic                        last_bit;
    logic                        word_done;
    logic signed [ACC_WIDTH:0]   acc_base;
    logic signed [ACC_WIDTH:0]   psum_ext;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic                        bin_bit;
    logic [8:0]                  new_word;

    assign last_pass = (pass_cnt_q == LAST_PASS);
    assign last_bit  = (bit_cnt_q == LAST_BIT);

    // Only the psum that would complete a word is held back while the output
    // register is still occupied and not being drained this cycle.
    assign psum_ready_out = !(vld_q && !act_ready_in && last_pass && last_bit);
    assign accept         = psum_valid_in && psum_ready_out;
    assign word_done      = accept && last_pass && last_bit;

    always_comb begin
        // The first pass of a group starts from zero rather than the stale sum.
        acc_base = (pass_cnt_q == '0) ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        psum_ext = {{(ACC_WIDTH+1-WIDTH){psum_in[WIDTH-1]}}, psum_in};
        sum_wide = acc_base + psum_ext;
        sum_sat  = sat_acc(sum_wide);
        bin_bit  = (sum_sat >= thr_q);
        new_word = {pack_q, bin_bit};
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        pack_d     = pack_q;
        out_d      = out_q;
        vld_d      = vld_q;

        if (accept) begin
            acc_d      = sum_sat;
            pass_cnt_d = last_pass ? '0 : pass_cnt_q + 1'b1;
            if (last_pass) begin
                bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                if (last_bit) begin
                    pack_d = '0;
                end else begin
                    pack_d[4'd8 - bit_cnt_q] = bin_bit;
                end
            end
        end

        // A completing word wins over a transfer: the register reloads and
        // valid stays high, so back-to-back words have no bubble.
        if (word_done) begin
            out_d = new_word;
            vld_d = 1'b1;
        end else if (vld_q && act_ready_in) begin
            vld_d = 1'b0;
        end

        // A compare in the load cycle still sees the old threshold.
        thr_d = thr_load_in ? thr_in : thr_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pass_cnt_q <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            thr_q      <= '0;
            pack_q     <= '0;
            out_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            thr_q      <= thr_d;
            pack_q     <= pack_d;
            out_q      <= out_d;
            vld_q      <= vld_d;
        end
    end

    assign act_out       = out_q;
    assign act_valid_out = vld_q;

endmodule

// File: tb/tb_psum_binarizer.sv
// -----------------------------------------------------------------------------
// tb_psum_binarizer
//
// Bench for psum_binarizer. A queue-based reference model tracks the main
// instance every cycle; directed tables and sequences cover packing, signed
// threshold compare, backpressure, reset and threshold-load timing. A second
// instance with a 14-bit accumulator covers saturation.
// -----------------------------------------------------------------------------
module tb_psum_binarizer;

    localparam int WIDTH     = 14;
    localparam int ACC_WIDTH = 16;
    localparam int PASSES    = 4;
    localparam int ACC_MAX   = (1 << (ACC_WIDTH - 1)) - 1;
    localparam int ACC_MIN   = -(1 << (ACC_WIDTH - 1));
    localparam int SEND_LIMIT = 20;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        psum_valid = 1'b0;
    logic signed [WIDTH-1:0]     psum = '0;
    logic                        psum_ready;
    logic                        thr_load = 1'b0;
    logic signed [ACC_WIDTH-1:0] thr = '0;
    logic [8:0]                  act;
    logic                        act_valid;
    logic                        act_ready = 1'b1;

    // Saturation instance: accumulator as narrow as the psum.
    logic                        s_valid = 1'b0;
    logic signed [13:0]          s_psum = '0;
    logic                        s_ready;
    logic                        s_load = 1'b0;
    logic signed [13:0]          s_thr = '0;
    logic [8:0]                  s_act;
    logic                        s_act_valid;
    logic                        s_act_ready = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    psum_binarizer #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .PASSES(PASSES)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .psum_valid_in (psum_valid),
        .psum_in       (psum),
        .psum_ready_out(psum_ready),
        .thr_load_in   (thr_load),
        .thr_in        (thr),
        .act_out       (act),
        .act_valid_out (act_valid),
        .act_ready_in  (act_ready)
    );

    psum_binarizer #(.WIDTH(14), .ACC_WIDTH(14), .PASSES(4)) dut_s (
        .clk_in        (clk),
        .rst_in        (rst),
        .psum_valid_in (s_valid),
        .psum_in       (s_psum),
        .psum_ready_out(s_ready),
        .thr_load_in   (s_load),
        .thr_in        (s_thr),
        .act_out       (s_act),
        .act_valid_out (s_act_valid),
        .act_ready_in  (s_act_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (main instance) ----------------
    int         m_pass = 0;
    int         m_sum  = 0;
    int         m_thr  = 0;
    bit         m_bits[$];
    logic [8:0] m_out  = '0;
    bit         m_vld  = 1'b0;

    function automatic bit model_ready(input bit ar);
        return !(m_vld && !ar && m_pass == PASSES - 1 && m_bits.size() == 8);
    endfunction

    task automatic model_step();
        bit         nw;
        logic [8:0] w;
        int         s;
        nw = 1'b0;
        w  = '0;
        if (rst) begin
            m_pass = 0; m_sum = 0; m_thr = 0; m_bits.delete();
            m_out = '0; m_vld = 1'b0;
        end else begin
            if (psum_valid && model_ready(act_ready)) begin
                s = (m_pass == 0 ? 0 : m_sum) + int'(psum);
                if (s > ACC_MAX) s = ACC_MAX;
                if (s < ACC_MIN) s = ACC_MIN;
                m_sum  = s;
                m_pass = m_pass + 1;
                if (m_pass == PASSES) begin
                    m_pass = 0;
                    m_bits.push_back(s >= m_thr);
                    if (m_bits.size() == 9) begin
                        foreach (m_bits[i]) w[8-i] = m_bits[i];
                        m_bits.delete();
                        nw = 1'b1;
                    end
                end
            end
            if (nw) begin
                m_out = w;
                m_vld = 1'b1;
            end else if (m_vld && act_ready) begin
                m_vld = 1'b0;
            end
            if (thr_load) m_thr = int'(thr);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("model_ready", psum_ready, model_ready(act_ready));
        chk("model_valid", act_valid, m_vld);
        chk("model_act",   act,       m_out);
    end

    // ---------------- stimulus helpers (called just after a negedge) -----
    task automatic send(input int v);
        int w;
        w = 0;
        psum_valid = 1'b1;
        psum = WIDTH'(v);
        #1;
        while (!psum_ready && w < SEND_LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("accept_in_time", (w < SEND_LIMIT) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    // Nine groups alternating sum +4 / -5; inv swaps which comes first.
    function automatic int alt_psum(input int k, input int p, input bit inv);
        if (((k % 2) == 0) != inv) return 1;
        return (p == 3) ? -2 : -1;
    endfunction

    task automatic feed_alt(input bit inv);
        for (int k = 0; k < 9; k++)
            for (int p = 0; p < PASSES; p++)
                send(alt_psum(k, p, inv));
    endtask

    task automatic load_thr(input int t);
        thr_load = 1'b1;
        thr = ACC_WIDTH'(t);
        @(negedge clk);
        thr_load = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic signed [15:0]       thr;
        logic [8:0][15:0]         sums;
        logic [8:0]               exp;
    } vec_t;

    function automatic vec_t mk(input int t, input int s0, input int s1, input int s2,
                                input int s3, input int s4, input int s5, input int s6,
                                input int s7, input int s8, input logic [8:0] e);
        vec_t v;
        v.thr = 16'(t);
        v.sums[0] = 16'(s0); v.sums[1] = 16'(s1); v.sums[2] = 16'(s2);
        v.sums[3] = 16'(s3); v.sums[4] = 16'(s4); v.sums[5] = 16'(s5);
        v.sums[6] = 16'(s6); v.sums[7] = 16'(s7); v.sums[8] = 16'(s8);
        v.exp = e;
        return v;
    endfunction

    vec_t vecs[4];

    initial begin
        int q, s;
        int tail[$];

        vecs[0] = mk(-5, -5, -6, -4, 0, -5, 8191, -8192, -5, -6, 9'b101111010);
        vecs[1] = mk(3, 3, 2, 4, -3, 3, 100, -100, 2, 3, 9'b101011001);
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h1FF);
        vecs[3] = mk(32767, 8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191, 9'h000);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_act", act, 9'h000);
        chk("reset_valid", act_valid, 0);
        chk("reset_ready", psum_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic packing with default threshold 0
        feed_alt(1'b0);
        chk("basic_valid", act_valid, 1);
        chk("basic_word", act, 9'b101010101);
        @(negedge clk);
        chk("basic_valid_one_cycle", act_valid, 0);

        // Table: threshold load, nine groups, one word
        for (int i = 0; i < 4; i++) begin
            load_thr(int'(vecs[i].thr));
            for (int k = 0; k < 9; k++) begin
                s = int'($signed(vecs[i].sums[k]));
                q = s / 4;
                send(q); send(q); send(q); send(s - 3 * q);
            end
            chk($sformatf("table%0d_valid", i), act_valid, 1);
            chk($sformatf("table%0d_word", i), act, vecs[i].exp);
            @(negedge clk);
            chk($sformatf("table%0d_drop", i), act_valid, 0);
        end

        // Saturation on the 14-bit accumulator instance
        s_load = 1'b1; s_thr = 14'sd8191;
        @(negedge clk);
        s_load = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int p = 0; p < 4; p++) begin
                s_psum = ((k % 2) == 0) ? 14'sd8191 : -14'sd8192;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        chk("sat_valid", s_act_valid, 1);
        chk("sat_word", s_act, 9'b101010101);

        // Backpressure: word 1 held, 35 accepts, the 36th stalls
        load_thr(0);
        act_ready = 1'b0;
        feed_alt(1'b0);
        chk("bp_word1_valid", act_valid, 1);
        for (int k = 0; k < 9; k++)
            for (int p = 0; p < PASSES; p++)
                tail.push_back(alt_psum(k, p, 1'b1));
        for (int i = 0; i < 35; i++) send(tail[i]);
        psum_valid = 1'b1;
        psum = WIDTH'(tail[35]);
        #1;
        chk("bp_stall_ready", psum_ready, 0);
        @(negedge clk);
        chk("bp_still_stalled", psum_ready, 0);
        chk("bp_word1_held", act, 9'b101010101);
        chk("bp_word1_valid_held", act_valid, 1);
        act_ready = 1'b1;
        #1;
        chk("bp_ready_released", psum_ready, 1);
        @(negedge clk);
        psum_valid = 1'b0;
        chk("bp_word2_valid", act_valid, 1);
        chk("bp_word2", act, 9'b010101010);
        @(negedge clk);
        chk("bp_word2_taken", act_valid, 0);

        // Reset mid-word with an undelivered word pending
        act_ready = 1'b0;
        feed_alt(1'b1);
        for (int i = 0; i < 20; i++) send(alt_psum(i / 4, i % 4, 1'b1));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_act", act, 9'h000);
        chk("midrst_valid", act_valid, 0);
        chk("midrst_ready", psum_ready, 1);
        rst = 1'b0;
        act_ready = 1'b1;
        @(negedge clk);
        feed_alt(1'b0);
        chk("midrst_word_valid", act_valid, 1);
        chk("midrst_word", act, 9'b101010101);
        @(negedge clk);

        // Threshold load in the same cycle as a compare uses the old value
        send(2); send(1); send(1);
        thr_load = 1'b1; thr = 16'sd10;
        send(1);
        thr_load = 1'b0;
        send(2); send(1); send(1); send(1);
        for (int k = 2; k < 9; k++) begin
            send(4); send(2); send(2); send(2);
        end
        chk("thr_timing_valid", act_valid, 1);
        chk("thr_timing_word", act, 9'b101111111);
        @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            psum_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                psum = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            else
                psum = WIDTH'(int'($urandom_range(0, 100)) - 50);
            act_ready = ($urandom_range(0, 3) != 0);
            thr_load = ($urandom_range(0, 31) == 0);
            thr = ACC_WIDTH'(int'($urandom_range(0, 400)) - 200);
            if (c == 1500) rst = 1'b1;
            else rst = 1'b0;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        thr_load = 1'b0;
        act_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
